// File: rtl/queen_pkg.sv
// Shared types and constants for the queen solver arbiter.
// States, result status encoding and the default board size.
package queen_pkg;

    localparam int BOARD_DEF    = 8;
    localparam int ABORT_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_CAPTURE,
        S_DRAIN,
        S_STATUS,
        S_ABORT
    } state_t;

    typedef enum logic [1:0] {
        STAT_NONE,
        STAT_NO_ANSWER,
        STAT_TIMEOUT,
        STAT_ERROR
    } status_t;

endpackage

// File: rtl/queen_solve_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping, plus the pointer value that follows the winner.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr,
    output logic          any
);

    logic found;
    int   idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        any      = |req;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/queen_solve_arbiter.sv
// Round-robin front end for one shared eight-queen solver: launch,
// watchdog, capture of the solution stream and drain to the owner.
module queen_solve_arbiter
    import queen_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BOARD   = BOARD_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               solver_start,
    output logic               solver_reset,
    input  logic               solver_ready,
    input  logic               solver_done,
    input  logic               solver_no_answer,
    input  logic [7:0]         solver_bus,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_data,
    output logic               res_last,
    output logic               res_no_answer,
    output logic               res_timeout,
    output logic               res_error
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW = (BOARD > 1) ? $clog2(BOARD) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(BOARD - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);
    localparam logic [1:0]    AB_LAST  = 2'(ABORT_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    status_t            status_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] arb_grant;
    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      arb_next;
    logic               arb_any;
    logic [WW-1:0]      wdog_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      rd_q;
    logic [7:0]         buf_q [BOARD];
    logic [1:0]         abort_cnt_q;

    logic launch_ok;
    logic wd_expired;
    logic cap_last;
    logic abort_end;

    assign launch_ok  = solver_ready && arb_any;
    assign wd_expired = (wdog_q >= WD_LIMIT);
    assign cap_last   = (idx_q == LAST_IDX);
    assign abort_end  = (abort_cnt_q == AB_LAST);

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req      (req),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .next_ptr (arb_next),
        .any      (arb_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch_ok) state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                // done outranks no_answer, both outrank the watchdog
                if (solver_done) begin
                    state_d = (BOARD == 1) ? S_DRAIN : S_CAPTURE;
                end else if (solver_no_answer) begin
                    state_d = S_STATUS;
                end else if (wd_expired) begin
                    state_d = S_ABORT;
                end
            end
            S_CAPTURE: begin
                if (!solver_done) begin
                    state_d = S_STATUS;
                end else if (cap_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (res_ready && rd_q == LAST_IDX) state_d = S_IDLE;
            end
            S_STATUS: begin
                if (res_ready) state_d = S_IDLE;
            end
            S_ABORT: begin
                if (abort_end) state_d = S_STATUS;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        solver_start  = 1'b0;
        res_valid     = 1'b0;
        res_data      = 8'd0;
        res_last      = 1'b0;
        res_no_answer = 1'b0;
        res_timeout   = 1'b0;
        res_error     = 1'b0;
        unique case (state_q)
            S_LAUNCH: solver_start = 1'b1;
            S_DRAIN: begin
                res_valid = 1'b1;
                res_data  = buf_q[rd_q];
                res_last  = (rd_q == LAST_IDX);
            end
            S_STATUS: begin
                res_valid     = 1'b1;
                res_last      = 1'b1;
                res_no_answer = (status_q == STAT_NO_ANSWER);
                res_timeout   = (status_q == STAT_TIMEOUT);
                res_error     = (status_q == STAT_ERROR);
            end
            default: ;
        endcase
    end

    assign grant        = grant_q;
    assign solver_reset = !reset_n || (state_q == S_ABORT);

    // Watchdog counts from the launch cycle, so it reads N on the
    // Nth cycle after solver_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= '0;
            ptr_q       <= '0;
            wdog_q      <= '0;
            idx_q       <= '0;
            rd_q        <= '0;
            status_q    <= STAT_NONE;
            abort_cnt_q <= '0;
            for (int i = 0; i < BOARD; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (launch_ok) begin
                        grant_q  <= arb_grant;
                        ptr_q    <= arb_next;
                        wdog_q   <= '0;
                        idx_q    <= '0;
                        rd_q     <= '0;
                        status_q <= STAT_NONE;
                    end
                end
                S_LAUNCH: wdog_q <= wdog_q + 1'b1;
                S_RUN: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (solver_done) begin
                        buf_q[0] <= solver_bus;
                        idx_q    <= IW'(1);
                    end else if (solver_no_answer) begin
                        status_q <= STAT_NO_ANSWER;
                    end else if (wd_expired) begin
                        status_q    <= STAT_TIMEOUT;
                        abort_cnt_q <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (solver_done) begin
                        buf_q[idx_q] <= solver_bus;
                        idx_q        <= idx_q + 1'b1;
                    end else begin
                        status_q <= STAT_ERROR;
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        if (rd_q == LAST_IDX) begin
                            grant_q <= '0;
                        end else begin
                            rd_q <= rd_q + 1'b1;
                        end
                    end
                end
                S_STATUS: begin
                    if (res_ready) grant_q <= '0;
                end
                S_ABORT: abort_cnt_q <= abort_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_queen_solve_arbiter.sv
// Directed bench for queen_solve_arbiter: a vector table for one full
// run plus hand-written sequences for the multi-cycle corner cases.
module tb_queen_solve_arbiter;

    localparam int NR = 2;
    localparam int BD = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NR-1:0] req;
    logic [NR-1:0] grant;
    logic          solver_start;
    logic          solver_reset;
    logic          solver_ready;
    logic          solver_done;
    logic          solver_no_answer;
    logic [7:0]    solver_bus;
    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic          res_last;
    logic          res_no_answer;
    logic          res_timeout;
    logic          res_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] pat [8] = '{8'd0, 8'd4, 8'd7, 8'd5, 8'd2, 8'd6, 8'd1, 8'd3};

    typedef struct {
        logic [1:0]  req;
        logic        rdy;
        logic        rr;
        logic        done;
        logic [7:0]  bus;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs [18];

    queen_solve_arbiter #(
        .NUM_REQ (NR),
        .BOARD   (BD),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .grant            (grant),
        .solver_start     (solver_start),
        .solver_reset     (solver_reset),
        .solver_ready     (solver_ready),
        .solver_done      (solver_done),
        .solver_no_answer (solver_no_answer),
        .solver_bus       (solver_bus),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_last         (res_last),
        .res_no_answer    (res_no_answer),
        .res_timeout      (res_timeout),
        .res_error        (res_error)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {grant, solver_start, solver_reset, res_valid, res_data,
                res_last, res_no_answer, res_timeout, res_error};
    endfunction

    function automatic logic [16:0] mk(
        input logic [1:0] g, input logic st, input logic sr,
        input logic v, input logic [7:0] d, input logic l,
        input logic na, input logic to, input logic er);
        return {g, st, sr, v, d, l, na, to, er};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int i, input logic [1:0] rq,
                           input logic rdy, input logic rr,
                           input logic dn, input logic [7:0] bus,
                           input logic [16:0] exp);
        vecs[i].req  = rq;
        vecs[i].rdy  = rdy;
        vecs[i].rr   = rr;
        vecs[i].done = dn;
        vecs[i].bus  = bus;
        vecs[i].exp  = exp;
    endtask

    // Waits (bounded) for the grant; on arrival the DUT sits in LAUNCH.
    task automatic wait_grant(input logic [1:0] g, input string name);
        int n = 0;
        while (grant == '0 && n < 8) begin
            tick();
            n++;
        end
        chk({name, "_grant"}, 32'(grant), 32'(g));
        chk({name, "_start"}, 32'(solver_start), 32'd1);
        solver_ready = 1'b0;
    endtask

    task automatic stream(input int nb, input logic [7:0] base);
        tick();
        for (int k = 0; k < nb; k++) begin
            solver_done = 1'b1;
            solver_bus  = pat[k] ^ base;
            tick();
        end
        solver_done = 1'b0;
        solver_bus  = 8'd0;
    endtask

    task automatic drain(input logic [1:0] g, input logic [7:0] base,
                         input bit stall, input int stop, input string name);
        int beats = 0;
        int c = 0;
        while (beats < stop && c < 64) begin
            res_ready = stall ? (c % 3 == 0) : 1'b1;
            chk({name, "_valid"}, 32'(res_valid), 32'd1);
            chk({name, "_grant"}, 32'(grant), 32'(g));
            chk({name, "_data"}, 32'(res_data), 32'(pat[beats] ^ base));
            chk({name, "_last"}, 32'(res_last), 32'(beats == 7));
            if (res_ready) beats++;
            tick();
            c++;
        end
        res_ready = 1'b0;
        chk({name, "_beats"}, 32'(beats), 32'(stop));
    endtask

    task automatic chk_idle(input string name);
        chk(name, 32'(obs()), 32'(mk(2'b00, 0, 0, 0, 8'd0, 0, 0, 0, 0)));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        set_row(0, 2'b01, 1, 0, 0, 8'd0, mk(2'b01, 1, 0, 0, 8'd0, 0, 0, 0, 0));
        set_row(1, 2'b00, 0, 0, 0, 8'd0, mk(2'b01, 0, 0, 0, 8'd0, 0, 0, 0, 0));
        for (int r = 2; r <= 8; r++) begin
            set_row(r, 2'b00, 0, 0, 1, pat[r-2],
                    mk(2'b01, 0, 0, 0, 8'd0, 0, 0, 0, 0));
        end
        set_row(9, 2'b00, 0, 0, 1, pat[7],
                mk(2'b01, 0, 0, 1, pat[0], 0, 0, 0, 0));
        set_row(10, 2'b00, 0, 1, 1, 8'hff,
                mk(2'b01, 0, 0, 1, pat[1], 0, 0, 0, 0));
        for (int r = 11; r <= 16; r++) begin
            set_row(r, 2'b00, 0, 1, 0, 8'd0,
                    mk(2'b01, 0, 0, 1, pat[r-9], r == 16, 0, 0, 0));
        end
        set_row(17, 2'b00, 0, 1, 0, 8'd0, mk(2'b00, 0, 0, 0, 8'd0, 0, 0, 0, 0));

        reset_n          = 1'b0;
        req              = '0;
        solver_ready     = 1'b0;
        solver_done      = 1'b0;
        solver_no_answer = 1'b0;
        solver_bus       = 8'd0;
        res_ready        = 1'b0;
        #1;
        chk("reset_state", 32'(obs()), 32'(mk(2'b00, 0, 1, 0, 8'd0, 0, 0, 0, 0)));
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk_idle("reset_release");

        // solver busy: no grant
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("not_ready_grant", 32'(grant), 32'd0);
        end

        // single request, extra done beyond BOARD, req dropped mid-run
        for (int r = 0; r < 18; r++) begin
            req          = vecs[r].req;
            solver_ready = vecs[r].rdy;
            res_ready    = vecs[r].rr;
            solver_done  = vecs[r].done;
            solver_bus   = vecs[r].bus;
            tick();
            chk($sformatf("vec%0d", r), 32'(obs()), 32'(vecs[r].exp));
        end
        solver_done = 1'b0;
        res_ready   = 1'b0;

        // backpressure
        req          = 2'b01;
        solver_ready = 1'b1;
        wait_grant(2'b01, "bp");
        stream(8, 8'h10);
        drain(2'b01, 8'h10, 1'b1, 8, "bp");
        chk_idle("bp_end");
        req = 2'b00;

        // no answer
        req          = 2'b10;
        solver_ready = 1'b1;
        wait_grant(2'b10, "na");
        req = 2'b00;
        tick();
        solver_no_answer = 1'b1;
        tick();
        solver_no_answer = 1'b0;
        chk("na_beat", 32'(obs()), 32'(mk(2'b10, 0, 0, 1, 8'd0, 1, 1, 0, 0)));
        tick();
        chk("na_hold", 32'(obs()), 32'(mk(2'b10, 0, 0, 1, 8'd0, 1, 1, 0, 0)));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk_idle("na_end");

        // short stream; done and no_answer together on first byte
        req          = 2'b01;
        solver_ready = 1'b1;
        wait_grant(2'b01, "err");
        req = 2'b00;
        tick();
        solver_done      = 1'b1;
        solver_no_answer = 1'b1;
        solver_bus       = 8'd1;
        tick();
        solver_no_answer = 1'b0;
        solver_bus       = 8'd2;
        tick();
        solver_bus = 8'd3;
        tick();
        solver_done = 1'b0;
        solver_bus  = 8'd0;
        tick();
        chk("err_beat", 32'(obs()), 32'(mk(2'b01, 0, 0, 1, 8'd0, 1, 0, 0, 1)));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk_idle("err_end");

        // watchdog abort on a silent solver
        req          = 2'b10;
        solver_ready = 1'b1;
        wait_grant(2'b10, "to");
        req = 2'b00;
        for (int c = 1; c <= 17; c++) begin
            tick();
            chk($sformatf("to_sreset_c%0d", c), 32'(solver_reset),
                32'(c == 16 || c == 17));
        end
        tick();
        chk("to_beat", 32'(obs()), 32'(mk(2'b10, 0, 0, 1, 8'd0, 1, 0, 1, 0)));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk_idle("to_end");

        // reset in the middle of a drain
        req          = 2'b01;
        solver_ready = 1'b1;
        wait_grant(2'b01, "rst");
        stream(8, 8'h00);
        drain(2'b01, 8'h00, 1'b0, 3, "rst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs()), 32'(mk(2'b00, 0, 1, 0, 8'd0, 0, 0, 0, 0)));
        tick();
        chk("rst_held", 32'(obs()), 32'(mk(2'b00, 0, 1, 0, 8'd0, 0, 0, 0, 0)));
        reset_n = 1'b1;
        #1;
        chk_idle("rst_release");

        // contention from pointer 0: 01, 10, 01
        req          = 2'b11;
        solver_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] g;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            wait_grant(g, $sformatf("ct%0d", i));
            stream(8, 8'(i + 1));
            drain(g, 8'(i + 1), 1'b0, 8, $sformatf("ct%0d", i));
            chk_idle($sformatf("ct%0d_end", i));
            solver_ready = 1'b1;
        end
        req          = 2'b00;
        solver_ready = 1'b0;
        tick();
        chk_idle("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
